mar_burst_unit: RTL and testbench
=================================

// Module: mar_burst_unit
// PURPOSE
//   Parametrised memory address register with N selectable load sources.
//   Adds a burst engine: after a start, it drives a req/ack address stream of
//   burst_len+1 beats, adding STRIDE to the address after each accepted beat.
//   Sits between the control unit, the MBR/PC address paths and the memory port.
// PARAMETERS
//   ADDR_W  8  address width in bits
//   N_SRC   2  number of load sources (index 0 = highest priority)
//   LEN_W   4  width of burst_len; maximum burst is 2**LEN_W beats
//   STRIDE  1  post-increment applied after each acked beat (ADDR_W-bit value)
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous reset, active-high
//   ld_sel     in   N_SRC         load request per source; may be multi-hot
//   src_addr   in   N_SRC*ADDR_W  source i at bits [i*ADDR_W +: ADDR_W]
//   start      in   1             launch a burst (sampled only in IDLE)
//   burst_len  in   LEN_W         beats minus one, sampled with start
//   mem_ack    in   1             memory accepted the current beat
//   mar_addr   out  ADDR_W        registered address, also the memory address
//   mem_req    out  1             beat request, registered (high only in BURST)
//   busy       out  1             high in BURST and DONE
//   done       out  1             one-cycle pulse after the last beat is acked
//   addr_wrap  out  1             one-cycle pulse when an increment overflows
//   ld_drop    out  1             one-cycle pulse when a load is ignored
// BEHAVIOUR
//   Reset (rst=1 at a clk edge) is synchronous and active-high.
//   - It overrides all inputs.
//   - It forces state IDLE and clears mar_addr, the beat counter, mem_req,
//     busy, done, addr_wrap and ld_drop to 0. This applies mid-burst too.
//   - mem_req falls at that same edge; there is no completion and no done.
//   FSM states: IDLE -> BURST -> DONE -> IDLE.
//   IDLE:
//   - If any ld_sel bit is set, mar_addr <= src_addr of the lowest set index.
//     Other set bits are ignored without error.
//   - If start=1, beats_left <= burst_len and the next state is BURST.
//   - Load and start in the same cycle: the load is written first. The burst
//     begins next cycle from the newly loaded address.
//   BURST:
//   - mem_req=1 and the address is mar_addr. Both are held stable until ack.
//   - On mem_ack=1 with beats_left!=0:
//       mar_addr <= mar_addr+STRIDE (mod 2**ADDR_W); beats_left--.
//   - On mem_ack=1 with beats_left==0:
//       mar_addr <= mar_addr+STRIDE; next state is DONE; mem_req drops
//       the next cycle.
//   - Back-to-back acks complete one beat per cycle. Latency is
//     burst_len+1 acked cycles minimum.
//   - mem_ack outside BURST is ignored.
//   DONE: done=1 for exactly one cycle, busy=1, then the next state is IDLE.
//   The first start is accepted the cycle after DONE.
//   busy is combinational from state: (state!=IDLE).
//   Loads:
//   - Any ld_sel bit set while busy: mar_addr is unchanged; ld_drop pulses
//     the next cycle.
//   - start while busy is ignored silently.
//   Wrap: the carry-out of mar_addr+STRIDE during an acked beat sets addr_wrap
//   for one cycle. The address wraps modulo 2**ADDR_W and the burst continues.
//   burst_len=0 gives a single beat. burst_len=all-ones gives 2**LEN_W beats.
//   ld_sel=0 and start=0 in IDLE: all registers hold.
// TESTING
//   1 Reset and priority. Assert rst, then ld_sel=2'b11 with src0=8'h12 and
//     src1=8'h34 -> mar_addr=0 after reset; mar_addr=8'h12 next cycle;
//     ld_drop=0.
//   2 Burst. Load 8'h40, start with burst_len=3, ack every cycle ->
//     mem_req high 4 cycles with addresses 40,41,42,43; done pulses once;
//     final mar_addr=8'h44.
//   3 Wait states. burst_len=1, ack held low 3 cycles per beat -> address
//     stable while req=1 and ack=0; exactly 2 beats; done after the 2nd ack.
//   4 Wrap. Load 8'hFE, STRIDE=1, burst_len=2 -> addresses FE,FF,00;
//     addr_wrap pulses on the FF ack; final mar_addr=8'h01.
//   5 Blocked load. ld_sel=2'b01 mid-burst -> mar_addr sequence unaffected;
//     ld_drop pulses next cycle. start mid-burst -> no effect.
//   6 Reset mid-burst. rst during beat 2 of 4 -> next cycle mem_req=0,
//     busy=0, mar_addr=0, done=0; a new start then runs normally.

Source files
------------

// File: rtl/mar_burst_unit.sv
// Memory address register with prioritised load sources and a req/ack burst
// engine that post-increments the address by STRIDE after every accepted beat.
module mar_burst_unit #(
    parameter int          ADDR_W = 8,
    parameter int          N_SRC  = 2,
    parameter int          LEN_W  = 4,
    parameter int unsigned STRIDE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_SRC-1:0]        ld_sel_i,
    input  logic [N_SRC*ADDR_W-1:0] src_addr_i,
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        burst_len_i,
    input  logic                    mem_ack_i,
    output logic [ADDR_W-1:0]       mar_addr_o,
    output logic                    mem_req_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    addr_wrap_o,
    output logic                    ld_drop_o
);

    localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_addr_q, mar_addr_d;
    logic [LEN_W-1:0]    beats_left_q, beats_left_d;
    logic                mem_req_q, mem_req_d;
    logic                addr_wrap_q, addr_wrap_d;
    logic                ld_drop_q, ld_drop_d;

    logic [ADDR_W-1:0]   src_arr [N_SRC];
    logic [ADDR_W-1:0]   ld_addr;
    logic                ld_any;
    logic                beat_acc;
    logic [ADDR_W:0]     inc_sum;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign src_arr[gi] = src_addr_i[gi*ADDR_W +: ADDR_W];
    end

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        ld_addr = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (ld_sel_i[i]) begin
                ld_addr = src_arr[i];
            end
        end
    end

    assign ld_any   = |ld_sel_i;
    assign beat_acc = (state_q == ST_BURST) && mem_ack_i;
    assign inc_sum  = {1'b0, mar_addr_q} + {1'b0, STRIDE_V};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mar_addr_q   <= '0;
            beats_left_q <= '0;
            mem_req_q    <= 1'b0;
            addr_wrap_q  <= 1'b0;
            ld_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mar_addr_q   <= mar_addr_d;
            beats_left_q <= beats_left_d;
            mem_req_q    <= mem_req_d;
            addr_wrap_q  <= addr_wrap_d;
            ld_drop_q    <= ld_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_BURST;
            ST_BURST: if (beat_acc && (beats_left_q == '0)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: loads only land in IDLE; acked beats always advance.
    always_comb begin
        mar_addr_d   = mar_addr_q;
        beats_left_d = beats_left_q;
        ld_drop_d    = ld_any && (state_q != ST_IDLE);
        addr_wrap_d  = beat_acc && inc_sum[ADDR_W];
        mem_req_d    = (state_d == ST_BURST);
        if (state_q == ST_IDLE) begin
            if (ld_any) begin
                mar_addr_d = ld_addr;
            end
            if (start_i) begin
                beats_left_d = burst_len_i;
            end
        end
        if (beat_acc) begin
            mar_addr_d = inc_sum[ADDR_W-1:0];
            if (beats_left_q != '0) begin
                beats_left_d = beats_left_q - LEN_W'(1);
            end
        end
    end

    always_comb begin
        mar_addr_o  = mar_addr_q;
        mem_req_o   = mem_req_q;
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        addr_wrap_o = addr_wrap_q;
        ld_drop_o   = ld_drop_q;
    end

endmodule

// File: tb/tb_mar_burst_unit.sv
// Directed and randomised bursts against an address-arithmetic reference model.
module tb_mar_burst_unit;

    localparam int          ADDR_W = 8;
    localparam int          N_SRC  = 2;
    localparam int          LEN_W  = 4;
    localparam int unsigned STRIDE = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_SRC-1:0]        ld_sel;
    logic [N_SRC*ADDR_W-1:0] src_addr;
    logic                    start;
    logic [LEN_W-1:0]        burst_len;
    logic                    mem_ack;
    logic [ADDR_W-1:0]       mar_addr;
    logic                    mem_req;
    logic                    busy;
    logic                    done;
    logic                    addr_wrap;
    logic                    ld_drop;

    int checks = 0;
    int errors = 0;
    logic [7:0] mar_model;

    always #5 clk = ~clk;

    mar_burst_unit #(
        .ADDR_W(ADDR_W),
        .N_SRC (N_SRC),
        .LEN_W (LEN_W),
        .STRIDE(STRIDE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ld_sel_i   (ld_sel),
        .src_addr_i (src_addr),
        .start_i    (start),
        .burst_len_i(burst_len),
        .mem_ack_i  (mem_ack),
        .mar_addr_o (mar_addr),
        .mem_req_o  (mem_req),
        .busy_o     (busy),
        .done_o     (done),
        .addr_wrap_o(addr_wrap),
        .ld_drop_o  (ld_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address of beat k of a burst starting at base: plain modular arithmetic.
    function automatic logic [7:0] addr_at(input logic [7:0] base, input int k);
        longint unsigned s;
        s = longint'(base) + longint'(k) * longint'(STRIDE);
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] lowest_src(input logic [1:0] sel, input logic [15:0] src);
        logic [7:0] s0;
        logic [7:0] s1;
        s0 = src[7:0];
        s1 = src[15:8];
        if (sel[0]) return s0;
        if (sel[1]) return s1;
        return mar_model;
    endfunction

    task automatic idle_step(input logic [1:0] sel, input logic [15:0] src, input logic ack);
        logic [7:0] exp_addr;
        exp_addr = lowest_src(sel, src);
        ld_sel = sel; src_addr = src; mem_ack = ack; start = 1'b0;
        tick();
        mar_model = exp_addr;
        chk("idle_mar", mar_addr, exp_addr);
        chk("idle_ld_drop", ld_drop, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_req", mem_req, 1'b0);
        chk("idle_done", done, 1'b0);
        ld_sel = '0;
        mem_ack = 1'b0;
        $display("idle sel=%b src=%h mar=%h", sel, src, mar_addr);
    endtask

    task automatic run_burst(input logic [7:0] base, input int len, input int wmin,
                             input int wmax, input bit interfere);
        logic [7:0] cur;
        logic [7:0] fin;
        int waits;
        bit exp_wrap;
        int wrap_seen;
        wrap_seen = 0;
        ld_sel    = {1'($urandom_range(0, 1)), 1'b1};
        src_addr  = {8'($urandom), base};
        start     = 1'b1;
        burst_len = 4'(len);
        mem_ack   = 1'($urandom_range(0, 1));
        tick();
        ld_sel = '0; start = 1'b0; mem_ack = 1'b0;
        for (int k = 0; k <= len; k++) begin
            cur   = addr_at(base, k);
            waits = $urandom_range(wmax, wmin);
            for (int w = 0; w <= waits; w++) begin
                chk("beat_req", mem_req, 1'b1);
                chk("beat_addr", mar_addr, cur);
                chk("beat_busy", busy, 1'b1);
                chk("beat_done", done, 1'b0);
                mem_ack = (w == waits);
                if (interfere) begin
                    ld_sel    = 2'($urandom);
                    src_addr  = 16'($urandom);
                    start     = 1'($urandom);
                    burst_len = 4'($urandom);
                end else begin
                    ld_sel = '0;
                    start  = 1'b0;
                end
                exp_wrap = mem_ack && ((int'(cur) + int'(STRIDE)) > 255);
                tick();
                chk("beat_ld_drop", ld_drop, ld_sel != '0);
                chk("beat_wrap", addr_wrap, exp_wrap);
                if (exp_wrap) wrap_seen++;
            end
        end
        fin = addr_at(base, len + 1);
        mem_ack = 1'b0; ld_sel = '0; start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("done_req", mem_req, 1'b0);
        chk("done_addr", mar_addr, fin);
        mem_ack = 1'($urandom);
        if (interfere) begin
            ld_sel = 2'($urandom);
            src_addr = 16'($urandom);
            start = 1'($urandom);
        end
        tick();
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_req", mem_req, 1'b0);
        chk("post_addr", mar_addr, fin);
        chk("post_ld_drop", ld_drop, ld_sel != '0);
        chk("post_wrap", addr_wrap, 1'b0);
        ld_sel = '0; start = 1'b0; mem_ack = 1'b0;
        mar_model = fin;
        $display("burst base=%h len=%0d waits=%0d..%0d intf=%0d wraps=%0d final=%h",
                 base, len, wmin, wmax, interfere, wrap_seen, mar_addr);
    endtask

    initial begin
        rst = 1'b1; ld_sel = 2'b11; src_addr = 16'h3412; start = 1'b0;
        burst_len = '0; mem_ack = 1'b0; mar_model = '0;

        // Reset with loads pending, then lowest-index priority.
        tick();
        chk("rst_mar", mar_addr, 8'h00);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", addr_wrap, 1'b0);
        chk("rst_ld_drop", ld_drop, 1'b0);
        $display("reset mar=%h", mar_addr);
        rst = 1'b0;
        idle_step(2'b11, 16'h3412, 1'b0);
        idle_step(2'b10, 16'h3412, 1'b1);
        idle_step(2'b00, 16'hABCD, 1'b1);

        run_burst(8'h40, 3, 0, 0, 1'b0);
        run_burst(8'h10, 1, 3, 3, 1'b0);
        run_burst(8'hFE, 2, 0, 0, 1'b0);
        run_burst(8'h20, 3, 0, 2, 1'b1);
        run_burst(8'h77, 0, 0, 0, 1'b0);
        run_burst(8'hF5, 15, 0, 1, 1'b0);

        // Reset during beat 2 of 4.
        ld_sel = 2'b01; src_addr = 16'h0080; start = 1'b1; burst_len = 4'd3;
        tick();
        ld_sel = '0; start = 1'b0; mem_ack = 1'b1;
        tick();
        chk("mid_addr", mar_addr, 8'h81);
        chk("mid_req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", mem_req, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mar", mar_addr, 8'h00);
        chk("mid_rst_done", done, 1'b0);
        rst = 1'b0; mem_ack = 1'b0;
        tick();
        chk("mid_rst_done2", done, 1'b0);
        chk("mid_rst_busy2", busy, 1'b0);
        mar_model = 8'h00;
        $display("reset mid-burst mar=%h", mar_addr);
        run_burst(8'h90, 3, 0, 1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                idle_step(2'($urandom), 16'($urandom), 1'($urandom));
            end
            run_burst(8'($urandom), $urandom_range(0, 15), 0, 2, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
